// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose: serialises IF and MEM accesses onto one req/gnt/rvalid memory bus, data first.
// Latency: 3 cycles minimum from request seen in IDLE to ready (gnt in REQ, rvalid next cycle).
// Backpressure: stall_o holds the whole pipeline until every live request has been served.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_o,
    output logic              err_o,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q,     state_d;
    owner_t              owner_q,     owner_d;
    logic                bus_req_q,   bus_req_d;
    logic                bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                if_done_q,   if_done_d;
    logic                mem_done_q,  mem_done_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                err_q,       err_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic                data_pend;
    logic                fetch_pend;
    logic                timed_out;
    logic [DATA_W-1:0]   resp_dat;

    assign data_pend  = mem_req & ~mem_done_q;
    assign fetch_pend = if_req  & ~if_done_q;
    assign stall_o    = data_pend | fetch_pend;
    assign timed_out  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign resp_dat   = bus_rvalid ? bus_rdata : ERR_DATA;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        // Pipeline advances on this edge, so served flags are released for the next instruction.
        if (!stall_o) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (data_pend) begin
                    owner_d     = OWN_DATA;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_req_d   = 1'b1;
                    state_d     = REQ;
                end else if (fetch_pend) begin
                    owner_d     = OWN_FETCH;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_req_d   = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus_rvalid || timed_out) begin
                    if (owner_q == OWN_FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = resp_dat;
                    end else begin
                        mem_done_d = 1'b1;
                        if (!bus_we_q) begin
                            mem_rdata_d = resp_dat;
                        end
                    end
                    if (!bus_rvalid) begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset-abort sequence, random vectors vs. a cost model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT_CYC = 1023;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ready, mem_ready, stall_o, err_o;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TIMEOUT_CYC), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_o(stall_o), .err_o(err_o),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr, mr, we;
        logic [31:0] ia, ma, wd;
        logic [31:0] d_if, d_mem;
        int          gd_if, rd_if, gd_m, rd_m;   // rd < 0: bus never answers
        int          e_lat;
        logic [31:0] e_if, e_mem;
        logic        e_err;
    } vec_t;

    // Per-transaction bus responder configuration, indexed by transaction number.
    int          cfg_gd [0:511];
    int          cfg_rd [0:511];
    logic [31:0] cfg_dat[0:511];
    logic [31:0] rec_addr[$];
    logic [31:0] rec_wdata[$];
    logic        rec_we[$];
    int          stab_err;
    logic        force_rv;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_if, m_mem;
    logic        m_err;

    // Bus slave: grants after cfg_gd cycles, answers cfg_rd cycles after grant; checks REQ hold.
    initial begin : responder
        int ph, rcnt, cur;
        ph = 0; rcnt = 0; cur = 0; stab_err = 0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = force_rv;
            bus_rdata  = force_rv ? 32'h5A5A_5A5A : 32'h0;
            if (!rst_n) begin
                ph = 0;
            end else begin
                if (ph == 2 && bus_req) ph = 0;
                if (ph == 0 && bus_req) begin
                    cur = rec_addr.size();
                    rec_addr.push_back(bus_addr);
                    rec_we.push_back(bus_we);
                    rec_wdata.push_back(bus_wdata);
                    rcnt = 0;
                    ph   = 1;
                end
                if (ph == 1) begin
                    if (!bus_req || bus_addr != rec_addr[cur] || bus_we != rec_we[cur] ||
                        bus_wdata != rec_wdata[cur])
                        stab_err++;
                    if (rcnt == cfg_gd[cur % 512]) begin
                        bus_gnt = 1'b1;
                        ph      = 2;
                        rcnt    = 0;
                    end else begin
                        rcnt++;
                    end
                end else if (ph == 2 && cfg_rd[cur % 512] >= 0) begin
                    if (rcnt == cfg_rd[cur % 512]) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = cfg_dat[cur % 512];
                        ph         = 0;
                    end else begin
                        rcnt++;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Applies one pipeline cycle's requests, waits out the stall, checks, then advances.
    task automatic apply_vec(input vec_t v);
        int base, k, n, lim, ntx;
        logic [31:0] a0, a1;
        logic        w0;
        base = rec_addr.size();
        k = base;
        if (v.mr) begin
            cfg_gd[k % 512] = v.gd_m; cfg_rd[k % 512] = v.rd_m; cfg_dat[k % 512] = v.d_mem; k++;
        end
        if (v.ifr) begin
            cfg_gd[k % 512] = v.gd_if; cfg_rd[k % 512] = v.rd_if; cfg_dat[k % 512] = v.d_if;
        end
        if_req = v.ifr; if_addr = v.ia;
        mem_req = v.mr; mem_we = v.we; mem_addr = v.ma; mem_wdata = v.wd;
        #1;
        n = 0;
        lim = v.e_lat + 16;
        while (stall_o && n < lim) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(v.e_lat));
        chk("if_ready", 64'(if_ready), 64'(v.ifr));
        chk("mem_ready", 64'(mem_ready), 64'(v.mr));
        chk("if_rdata", 64'(if_rdata), 64'(v.e_if));
        chk("mem_rdata", 64'(mem_rdata), 64'(v.e_mem));
        chk("err_o", 64'(err_o), 64'(v.e_err));
        ntx = rec_addr.size() - base;
        chk("grants", 64'(ntx), 64'(int'(v.ifr) + int'(v.mr)));
        a0 = (ntx > 0) ? rec_addr[base] : 32'hFFFF_FFFF;
        w0 = (ntx > 0) ? rec_we[base] : 1'bx;
        a1 = (ntx > 1) ? rec_addr[base + 1] : 32'hFFFF_FFFF;
        if (v.mr) begin
            chk("data_addr", 64'(a0), 64'(v.ma));
            chk("data_we", 64'(w0), 64'(v.we));
            if (v.we) chk("data_wdata", 64'((ntx > 0) ? rec_wdata[base] : 32'hFFFF_FFFF), 64'(v.wd));
            if (v.ifr) chk("fetch_addr_2nd", 64'(a1), 64'(v.ia));
        end else if (v.ifr) begin
            chk("fetch_addr", 64'(a0), 64'(v.ia));
            chk("fetch_we", 64'(w0), 64'(1'b0));
        end
        @(posedge clk);
        @(negedge clk);
        chk("ready_clear", 64'({if_ready, mem_ready}), 64'(2'b00));
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    endtask

    // Reference: each served access costs 3 cycles plus its grant and response waits.
    task automatic run_model(input vec_t v);
        v.e_lat = (v.mr ? 3 + v.gd_m + v.rd_m : 0) + (v.ifr ? 3 + v.gd_if + v.rd_if : 0);
        if (v.ifr) m_if = v.d_if;
        if (v.mr && !v.we) m_mem = v.d_mem;
        v.e_if  = m_if;
        v.e_mem = m_mem;
        v.e_err = m_err;
        apply_vec(v);
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin : main
        int base;
        rst_n = 1'b0; force_rv = 1'b0;
        if_req = 0; mem_req = 0; mem_we = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0;

        //        ifr  mr  we  ia     ma      wd      d_if          d_mem  gdi rdi gdm rdm lat              e_if          e_mem         e_err
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h8C01_0004, 32'h0, 0, 0, 0, 0, 3,
                   32'h8C01_0004, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 32'h22, 32'h11, 0, 0, 0, 0, 6,
                   32'h22, 32'h11, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'hCAFE, 32'h0, 32'h9999, 0, 0, 5, 0, 8,
                   32'h22, 32'h11, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h0, 32'h7777, 0, 0, 0, -1, TIMEOUT_CYC + 2,
                   32'h22, 32'hDEAD_BEEF, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 32'h1234, 32'h0, 1, 2, 0, 0, 6,
                   32'h1234, 32'hDEAD_BEEF, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'({bus_req, bus_we, if_ready, mem_ready, err_o, stall_o}), 64'(6'b0));
        chk("rst_rdata", 64'({if_rdata, mem_rdata}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) apply_vec(tbl[i]);

        // Abort a load stuck in RESP with reset, then throw a stray rvalid at IDLE.
        base = rec_addr.size();
        cfg_gd[base % 512] = 0; cfg_rd[base % 512] = -1; cfg_dat[base % 512] = 32'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
        repeat (4) @(negedge clk);
        chk("pre_reset_stall", 64'({stall_o, bus_req}), 64'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 64'({bus_req, bus_we, if_ready, mem_ready, err_o}), 64'(5'b0));
        chk("abort_data", 64'({if_rdata, mem_rdata}), 64'(0));
        chk("abort_bus", 64'({bus_addr, bus_wdata}), 64'(0));
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 force_rv = 1'b1;
        @(negedge clk);
        #1 force_rv = 1'b0;
        @(negedge clk);
        chk("stray_rvalid", 64'({if_ready, mem_ready, stall_o, bus_req}), 64'(4'b0));
        chk("stray_rdata", 64'({if_rdata, mem_rdata}), 64'(0));

        m_if = 32'h0; m_mem = 32'h0; m_err = 1'b0;
        rv = '{1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 0, 0, 0, 0,
               32'h0, 32'h0, 1'b0};
        run_model(rv);

        for (int i = 0; i < 40; i++) begin
            rv.ifr   = 1'($urandom_range(0, 1));
            rv.mr    = 1'($urandom_range(0, 1));
            rv.we    = 1'($urandom_range(0, 1));
            rv.ia    = $urandom & 32'hFFFF_FFFC;
            rv.ma    = $urandom & 32'hFFFF_FFFC;
            rv.wd    = $urandom;
            rv.d_if  = $urandom;
            rv.d_mem = $urandom;
            rv.gd_if = $urandom_range(0, 3);
            rv.rd_if = $urandom_range(0, 3);
            rv.gd_m  = $urandom_range(0, 3);
            rv.rd_m  = $urandom_range(0, 3);
            run_model(rv);
        end

        chk("bus_hold_violations", 64'(stab_err), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
